// File: rtl/ram_pkg.sv
// ram_pkg: read-during-write mode constants, clear-FSM state type and byte-lane count helper shared by ram_sdp and ram_clear_fsm
package ram_pkg;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  typedef enum logic {CLEAR, READY} state_t;
  function automatic int nbytes(input int dw, input int bw);
    return dw / bw;
  endfunction
endpackage

// File: rtl/ram_clear_fsm.sv
// ram_clear_fsm: post-reset clear sweep (clk, rst in; busy, clr_we, clr_addr out) that zeroes every word once, then idles in READY
module ram_clear_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 11,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= busy ? cnt + 1'b1 : cnt;
    end
  always_comb begin
    state_n  = (state == CLEAR && cnt == '1) ? READY : state;
    busy     = state == CLEAR;
    clr_we   = busy;
    clr_addr = cnt;
  end
endmodule

// File: rtl/ram_sdp.sv
// ram_sdp: simple-dual-port RAM (clk, rst; wr_en/wr_be/wr_addr/wr_data; rd_en/rd_addr -> rd_data/rd_valid/rd_addr_out; busy) with byte enables, RDW_MODE, clear sweep; RAM_OUT_REG_EN adds a second output stage
module ram_sdp
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 11,
  parameter int BYTE_WIDTH     = 8,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NBYTES        = nbytes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [NBYTES-1:0]     wr_be,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  output logic                  busy
);
  logic                  clr_we, we, rd_fire, v1;
  logic [ADDR_WIDTH-1:0] clr_addr, wa, a1;
  logic [NBYTES-1:0]     be;
  logic [DATA_WIDTH-1:0] wd, rd_word, q1;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  ram_clear_fsm #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clr (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );
  always_comb begin
    we      = busy ? clr_we : wr_en;
    be      = busy ? '1 : wr_be;
    wa      = busy ? clr_addr : wr_addr;
    wd      = busy ? '0 : wr_data;
    rd_fire = rd_en && !busy;
    rd_word = mem[rd_addr];
    for (int i = 0; i < NBYTES; i++)
      if (RDW_MODE != RDW_OLD && wr_en && wr_be[i] && wr_addr == rd_addr)
        rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NBYTES; i++)
      if (we && be[i]) mem[wa][i*BYTE_WIDTH +: BYTE_WIDTH] <= wd[i*BYTE_WIDTH +: BYTE_WIDTH];
  always_ff @(posedge clk)
    if (rst) begin
      q1 <= '0;
      v1 <= 1'b0;
      a1 <= '0;
    end else begin
      v1 <= rd_fire;
      q1 <= rd_fire ? rd_word : q1;
      a1 <= rd_fire ? rd_addr : a1;
    end
`ifdef RAM_OUT_REG_EN
  always_ff @(posedge clk)
    if (rst) begin
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      rd_addr_out <= '0;
    end else begin
      rd_valid    <= v1;
      rd_data     <= v1 ? q1 : rd_data;
      rd_addr_out <= v1 ? a1 : rd_addr_out;
    end
`else
  always_comb begin
    rd_data     = q1;
    rd_valid    = v1;
    rd_addr_out = a1;
  end
`endif
endmodule

// File: tb/tb_ram_sdp.sv
// tb_ram_sdp: scoreboard bench driving old-word and write-through ram_sdp instances with shared directed stimulus
module tb_ram_sdp;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  typedef struct packed {logic [3:0] a; logic [31:0] d;} exp_t;
  logic clk = 0, rst = 1, wr_en = 0, rd_en = 0;
  logic [3:0] wr_be = 0, wr_addr = 0, rd_addr = 0;
  logic [31:0] wr_data = 0;
  logic [31:0] rd0, rd1;
  logic v0, v1, b0, b1;
  logic [3:0] ra0, ra1;
  logic [5:0] vs0, vs1;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int checks = 0, errors = 0, n;
  always #5 clk = ~clk;
  ram_sdp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd0), .rd_valid(v0), .rd_addr_out(ra0), .busy(b0)
  );
  ram_sdp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd1), .rd_valid(v1), .rd_addr_out(ra1), .busy(b1)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (b0) chk("u0 rd_valid while busy", {31'b0, v0}, 0);
    if (b1) chk("u1 rd_valid while busy", {31'b0, v1}, 0);
    if (v0 === 1'b1) begin
      if (q0.size() == 0) chk("u0 unexpected rd_valid", {31'b0, v0}, 0);
      else begin
        e0 = q0.pop_front();
        chk("u0 rd_data", rd0, e0.d);
        chk("u0 rd_addr_out", {28'b0, ra0}, {28'b0, e0.a});
      end
    end
    if (v1 === 1'b1) begin
      if (q1.size() == 0) chk("u1 unexpected rd_valid", {31'b0, v1}, 0);
      else begin
        e1 = q1.pop_front();
        chk("u1 rd_data", rd1, e1.d);
        chk("u1 rd_addr_out", {28'b0, ra1}, {28'b0, e1.a});
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [3:0] a, input logic [31:0] d0, input logic [31:0] d1);
    q0.push_back({a, d0});
    q1.push_back({a, d1});
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1; wr_addr = a; wr_data = d; wr_be = be;
    cyc();
    wr_en = 0;
  endtask
  task automatic rd(input logic [3:0] a, input logic [31:0] d0, input logic [31:0] d1);
    rd_en = 1; rd_addr = a;
    push(a, d0, d1);
    cyc();
    rd_en = 0;
  endtask
  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (b0 && cnt < 100) begin
      if (cnt == 3) begin
        wr_en = 0;
        rd_en = 0;
      end
      cyc();
      cnt++;
    end
  endtask
  initial begin
    rst = 1;
    cyc();
    chk("reset rd_data", rd0, 0);
    chk("reset rd_valid", {31'b0, v0}, 0);
    chk("reset rd_addr_out", {28'b0, ra0}, 0);
    chk("reset busy u0", {31'b0, b0}, 1);
    chk("reset busy u1", {31'b0, b1}, 1);
    wr_en = 1; wr_be = 4'hF; wr_addr = 2; wr_data = 32'hFF;
    rd_en = 1; rd_addr = 2;
    rst = 0;
    wait_clear(n);
    chk("clear length", n, 16);
    chk("u1 busy after clear", {31'b0, b1}, 0);
    rd_en = 1; rd_addr = 5;
    push(5, 0, 0);
    cyc();
    rd_en = 0;
    if (LAT == 2) cyc();
    chk("read latency rd_valid", {31'b0, v0}, 1);
    rd(2, 0, 0);
    for (int i = 0; i < 16; i++) wr(4'(i), 32'hA5A50000 | i, 4'hF);
    rd(7, 32'hA5A50007, 32'hA5A50007);
    repeat (3) cyc();
    rst = 1;
    cyc();
    rst = 0;
    repeat (7) cyc();
    rst = 1;
    cyc();
    rst = 0;
    wait_clear(n);
    chk("clear length after mid-sweep reset", n, 16);
    for (int i = 0; i < 16; i++) rd(4'(i), 0, 0);
    wr(3, 32'hDEADBEEF, 4'hF);
    wr(3, 32'h11223344, 4'b0101);
    rd(3, 32'hDE22BE44, 32'hDE22BE44);
    wr(3, 0, 4'hF);
    wr_en = 1; wr_addr = 3; wr_data = 32'hAABBCCDD; wr_be = 4'b0011;
    rd_en = 1; rd_addr = 3;
    push(3, 32'h00000000, 32'h0000CCDD);
    cyc();
    wr_en = 0;
    rd(3, 32'h0000CCDD, 32'h0000CCDD);
    repeat (3) cyc();
    for (int k = 0; k < 6; k++) begin
      rd_en = k < 3; rd_addr = 4'(k);
      if (k < 3) push(4'(k), 0, 0);
      cyc();
      vs0[k] = v0;
      vs1[k] = v1;
    end
    chk("b2b rd_valid u0", {26'b0, vs0}, (LAT == 2) ? 32'b001110 : 32'b000111);
    chk("b2b rd_valid u1", {26'b0, vs1}, (LAT == 2) ? 32'b001110 : 32'b000111);
    repeat (4) cyc();
    chk("u0 scoreboard drained", 32'(q0.size()), 0);
    chk("u1 scoreboard drained", 32'(q1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_sdp.md
# ram_sdp

Parametrised simple-dual-port RAM: one write port and one read port on a single clock. It is the next generation of the team's single-port registered-address RAM, adding byte-write enables, a selectable read-during-write mode, read-valid signalling and a hardware clear sweep after reset. It serves as the general on-chip buffer for line buffers, FIFOs and lookup tables in later chapters.

## Interface
- DATA_WIDTH, 8: word width; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 11: address width; depth = 2**ADDR_WIDTH.
- BYTE_WIDTH, 8: byte-lane width; NBYTES = DATA_WIDTH/BYTE_WIDTH.
- RDW_MODE, 0: same-address read-during-write result.
  - 0 = old word.
  - 1 = write-through, merged per byte lane.
- CLEAR_ON_RESET, 1: when 1, memory is zeroed after every reset.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_en  in  1  write request.
- wr_be  in  NBYTES  per-lane write enable; bit i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data/rd_addr_out valid this cycle.
- rd_addr_out  out  ADDR_WIDTH  address that produced rd_data.
- busy  out  1  clear sweep in progress; requests ignored.

## Operation
- Reset values:
  - rd_data = 0, rd_valid = 0, rd_addr_out = 0.
  - busy = 1 if CLEAR_ON_RESET = 1, else 0.
  - FSM enters CLEAR if CLEAR_ON_RESET = 1, else READY.
  - Clear counter = 0.
- FSM states: CLEAR and READY.
  - CLEAR: writes 0 to mem[cnt] each cycle and increments cnt. When cnt = 2**ADDR_WIDTH-1, that last word is written and the FSM moves to READY on the next edge.
  - READY: normal operation; busy = 0.
- Reset asserted mid-sweep restarts the sweep at address 0. With CLEAR_ON_RESET = 0, reset leaves memory contents untouched.
- While busy: wr_en and rd_en are ignored, rd_valid stays 0 and rd_data holds its value.
- Write: on wr_en, each lane i with wr_be[i] = 1 is updated. wr_en with wr_be = 0 leaves memory unchanged.
- Read: on rd_en, mem[rd_addr] is registered to rd_data, rd_addr is registered to rd_addr_out, and rd_valid is set to 1.
  - Without rd_en, rd_valid = 0 and rd_data/rd_addr_out hold their values.
- Read-during-write, same address, same cycle:
  - RDW_MODE = 0: rd_data is the pre-write word.
  - RDW_MODE = 1: enabled lanes come from wr_data; other lanes are the old word.
  - Different addresses: the two ports are fully independent.
- Addresses wrap naturally at ADDR_WIDTH bits; there is no range error.

## Timing
- Read latency is 1 cycle: rd_en sampled at edge N gives rd_data, rd_valid and rd_addr_out after edge N. With RAM_OUT_REG_EN the latency is 2.
- A write at edge N is visible to a read issued at edge N+1 in both modes.
- Throughput is one read and one write per cycle, back-to-back, with no stalls outside CLEAR.
- Clear duration is 2**ADDR_WIDTH cycles after rst deasserts: busy falls after edge 2**ADDR_WIDTH.

## Configuration
- RAM_OUT_REG_EN defined:
  - Adds a second output register stage; read latency becomes 2.
  - rd_valid and rd_addr_out are delayed to stay aligned with rd_data.
  - rst clears both stages.
  - A read issued in the last CLEAR cycle cannot occur, because requests are ignored while busy.
- RAM_OUT_REG_EN undefined: single output stage, latency 1.

## Structure
- Shared package ram_pkg holds:
  - Constants RDW_OLD = 0 and RDW_NEW = 1.
  - The FSM state typedef (CLEAR, READY).
  - The NBYTES derivation function.
- Sub-module ram_clear_fsm holds the state register, clear counter and busy flag. It outputs clr_we and clr_addr, which the top muxes onto the write port.
- Memory array, byte-lane write loop, RDW merge and output registers live in ram_sdp.

## Test plan
- CLEAR_ON_RESET = 1, ADDR_WIDTH = 4:
  - Pulse rst for 1 cycle: busy is high for exactly 16 cycles.
  - Then read addr 5: rd_data = 0x00 and rd_valid = 1 one cycle later.
- Reset mid-sweep: assert rst at cnt = 7 → sweep restarts from 0, busy is high for 16 more cycles, and every address reads 0 afterwards.
- Byte enables, DATA_WIDTH = 32:
  - Write 0xDEADBEEF to addr 3 with wr_be = 4'hF.
  - Then write 0x11223344 to addr 3 with wr_be = 4'b0101.
  - Read addr 3 → 0xDE22BE44.
- RDW, addr 3 holds 0x00000000: same-cycle wr_en/rd_en to addr 3 with wr_data = 0xAABBCCDD, wr_be = 4'b0011.
  - RDW_MODE = 0 → rd_data = 0x00000000.
  - RDW_MODE = 1 → rd_data = 0x0000CCDD.
- Back-to-back reads of addr 0,1,2 on consecutive cycles → rd_addr_out = 0,1,2 and rd_valid = 1 for three consecutive cycles. With RAM_OUT_REG_EN the same sequence is shifted one cycle later.
- While busy, wr_en to addr 2 with 0xFF → after clear completes, a read of addr 2 returns 0x00 and rd_valid never asserted during busy.
